cpu_datapath: RTL and testbench
===============================

Name: cpu_datapath

Overview:
- Sequential datapath and fetch/execute sequencer of the nic8 CPU.
- Owns PC, IR, A, B, X, the carry flag, the ALU and the bus mux.
- Feeds IR, aIsZero and flagCarry to the instruction decoder, and consumes the 15-bit decoded control word the decoder returns.
- Sits between the decoder and the single-port program/data memory.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ctrl  in  15  decoded control word: {loadIR,loadPC,loadA,loadB,loadX,doOut,storeMem,assertM,assertE,assertA,assertX,immediate,jumpControl,doSubtract,doJump}.
- ir  out  8  instruction register, to the decoder.
- a_is_zero  out  1  (A == 0), combinational from the A register.
- flag_carry  out  1  carry flag register.
- mem_addr  out  8  memory address.
- mem_rdata  in  8  memory read data; combinational read of mem_addr in the same cycle.
- mem_wdata  out  8  write data; equals the bus.
- mem_we  out  1  memory write strobe; write happens at the rising edge.
- out_data  out  8  output port register.
- out_valid  out  1  one-cycle pulse when out_data is updated.
- phase  out  1  0 = FETCH, 1 = EXEC (debug).

Behaviour:
- Reset values: PC = RESET_PC, IR = A = B = X = out_data = 0, carry = 0, out_valid = 0, mem_we = 0, phase = FETCH.
- Reset is asynchronous and may land mid-EXEC. The in-flight instruction is abandoned and no write completes.

Two-state FSM:
- FETCH
  - mem_addr = PC.
  - IR <= mem_rdata, PC <= PC + 1 (wraps 8'hFF -> 8'h00).
  - Go to EXEC. ctrl is ignored; mem_we = 0.
- EXEC: performs one bus transfer, then returns to FETCH.

Bus source in EXEC (exactly one assert* is set; the decoder guarantees this):
- assertM -> mem_rdata.
- assertE -> ALU result.
- assertA -> A.
- assertX -> X.

Address in EXEC:
- If immediate: mem_addr = PC. If assertM is also set, PC increments at the edge (operand consumed). An immediate operand byte is always consumed when assertM is set, even if the jump is not taken.
- If indexed (!immediate): mem_addr = X.

ALU (8-bit):
- doSubtract = 0: E = A + B, cout = 9th bit.
- doSubtract = 1: E = A + ~B + 1, cout = 1 means no borrow.
- carry <= cout only on EXEC cycles with loadA or loadB and assertE. Otherwise carry holds.

Destination actions at the EXEC edge:
- loadA: A <= bus.
- loadB: B <= bus.
- loadX: X <= bus.
- doOut: out_data <= bus; out_valid = 1 for the following cycle only.
- storeMem: mem_we = 1 during EXEC, writing the bus to mem[X].
  - storeMem with assertM is illegal. mem_we is forced to 0 and the cycle is a no-op.
- loadPC:
  - If doJump, PC <= bus. Jump loading takes priority over the operand increment.
  - If not doJump, the cycle is a no-op apart from the operand increment.
- loadIR: IR <= bus and the FSM stays in EXEC (computed instruction); PC is not advanced except by the operand rule.

Other rules:
- jumpControl is unused internally; it is kept for trace only.
- a_is_zero and flag_carry are sampled by the decoder from registered state, so there is no combinational loop.

Optional Feature:
- Macro: CPU_HALT_DETECT_EN.
- With the macro defined:
  - Adds output halted (1 bit, reset 0).
  - In EXEC with doJump and bus == (PC - 1), i.e. a jump to its own instruction, halted sets sticky. The FSM then freezes: no further fetches, mem_we = 0, out_valid = 0.
  - Only reset clears halted.
- Without the macro: no halted port; a self-jump loops forever.

Decomposition:
- Shared package cpu_pkg:
  - CTRL_W = 15 and the bit-index constants for each control field.
  - Phase encoding (PH_FETCH = 0, PH_EXEC = 1).
  - RESET_PC default.
- Natural sub-module: cpu_alu, combinational. Takes a, b, sub; returns e[7:0] and cout.

Test Plan:
- Reset during EXEC with storeMem pending -> mem_we = 0 immediately; PC = 8'h00, phase = FETCH, all registers 0.
- mem[0] = load-A-immediate, mem[1] = 8'h05 -> after 2 cycles A = 8'h05, PC = 8'h02, a_is_zero = 0.
- A = 8'hF0, B = 8'h20, load A from E (add) -> A = 8'h10, carry = 1. Then A = 8'h10, B = 8'h20 with subtract -> A = 8'hF0, carry = 0.
- Conditional jump not taken (doJump = 0) at PC = 8'h04, operand 8'h40 -> PC = 8'h06, not 8'h40. Same with doJump = 1 -> PC = 8'h40.
- X = 8'h80, storeMem from A = 8'h3C -> mem_we pulse, mem_addr = 8'h80, mem_wdata = 8'h3C. A doOut of 8'h3C -> out_valid high exactly one cycle.
- CPU_HALT_DETECT_EN: unconditional jump at 8'h10 with operand 8'h10 -> halted = 1, PC frozen for 20 cycles, no mem_we.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the nic8 datapath: control-word layout, phase encoding, reset PC.
package cpu_pkg;

    localparam int CTRL_W = 15;

    localparam int C_LOAD_IR      = 14;
    localparam int C_LOAD_PC      = 13;
    localparam int C_LOAD_A       = 12;
    localparam int C_LOAD_B       = 11;
    localparam int C_LOAD_X       = 10;
    localparam int C_DO_OUT       = 9;
    localparam int C_STORE_MEM    = 8;
    localparam int C_ASSERT_M     = 7;
    localparam int C_ASSERT_E     = 6;
    localparam int C_ASSERT_A     = 5;
    localparam int C_ASSERT_X     = 4;
    localparam int C_IMMEDIATE    = 3;
    localparam int C_JUMP_CONTROL = 2;
    localparam int C_DO_SUBTRACT  = 1;
    localparam int C_DO_JUMP      = 0;

    localparam logic [0:0] PH_FETCH = 1'b0;
    localparam logic [0:0] PH_EXEC  = 1'b1;

    localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;

endpackage

// File: rtl/cpu_alu.sv
// 8-bit add/subtract unit; subtraction is A + ~B + 1 so cout = 1 means no borrow.
module cpu_alu (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       sub_i,
    output logic [7:0] e_o,
    output logic       cout_o
);

    logic [8:0] sum;
    logic [7:0] bOperand;

    always_comb begin
        bOperand = sub_i ? ~b_i : b_i;
        sum      = {1'b0, a_i} + {1'b0, bOperand} + {8'h00, sub_i};
        e_o      = sum[7:0];
        cout_o   = sum[8];
    end

endmodule

// File: rtl/cpu_datapath.sv
// nic8 datapath and two-phase fetch/execute sequencer.
// Optional macro CPU_HALT_DETECT_EN adds a sticky 'halted' output that freezes the core on a self-jump.
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [7:0]        ir,
    output logic              a_is_zero,
    output logic              flag_carry,
    output logic [7:0]        mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic [7:0]        out_data,
    output logic              out_valid,
`ifdef CPU_HALT_DETECT_EN
    output logic              halted,
`endif
    output logic              phase
);

    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] x_q, x_d;
    logic [7:0] out_q, out_d;
    logic       carry_q, carry_d;
    logic       outValid_q, outValid_d;
    logic [0:0] phase_q, phase_d;
    logic       halted_q, halted_d;

    logic [7:0] bus;
    logic [7:0] aluE;
    logic       aluCout;
    logic       isExec;
    logic       frozen;
    logic       unusedJumpControl;

    assign unusedJumpControl = ctrl[C_JUMP_CONTROL];

    cpu_alu u_alu (
        .a_i    (a_q),
        .b_i    (b_q),
        .sub_i  (ctrl[C_DO_SUBTRACT]),
        .e_o    (aluE),
        .cout_o (aluCout)
    );

`ifdef CPU_HALT_DETECT_EN
    assign frozen = halted_q;
    assign halted = halted_q;
`else
    assign frozen = 1'b0;
`endif

    assign isExec = (phase_q == PH_EXEC) && !frozen;

    always_comb begin
        if (ctrl[C_ASSERT_M])      bus = mem_rdata;
        else if (ctrl[C_ASSERT_E]) bus = aluE;
        else if (ctrl[C_ASSERT_A]) bus = a_q;
        else if (ctrl[C_ASSERT_X]) bus = x_q;
        else                       bus = 8'h00;
    end

    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        x_d        = x_q;
        out_d      = out_q;
        carry_d    = carry_q;
        outValid_d = 1'b0;
        phase_d    = phase_q;
        halted_d   = halted_q;
        mem_addr   = pc_q;

        if (!frozen) begin
            if (phase_q == PH_FETCH) begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + 8'd1;
                phase_d = PH_EXEC;
            end else begin
                mem_addr = ctrl[C_IMMEDIATE] ? pc_q : x_q;
                // The operand byte is consumed first; a taken jump then overrides it.
                if (ctrl[C_IMMEDIATE] && ctrl[C_ASSERT_M]) pc_d = pc_q + 8'd1;
                if (ctrl[C_LOAD_PC] && ctrl[C_DO_JUMP])    pc_d = bus;
                if (ctrl[C_LOAD_A]) a_d = bus;
                if (ctrl[C_LOAD_B]) b_d = bus;
                if (ctrl[C_LOAD_X]) x_d = bus;
                if (ctrl[C_DO_OUT]) begin
                    out_d      = bus;
                    outValid_d = 1'b1;
                end
                if ((ctrl[C_LOAD_A] || ctrl[C_LOAD_B]) && ctrl[C_ASSERT_E]) carry_d = aluCout;
                if (ctrl[C_LOAD_IR]) begin
                    ir_d    = bus;
                    phase_d = PH_EXEC;
                end else begin
                    phase_d = PH_FETCH;
                end
                if (ctrl[C_DO_JUMP] && (bus == pc_q - 8'd1)) halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            ir_q       <= 8'h00;
            a_q        <= 8'h00;
            b_q        <= 8'h00;
            x_q        <= 8'h00;
            out_q      <= 8'h00;
            carry_q    <= 1'b0;
            outValid_q <= 1'b0;
            phase_q    <= PH_FETCH;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            x_q        <= x_d;
            out_q      <= out_d;
            carry_q    <= carry_d;
            outValid_q <= outValid_d;
            phase_q    <= phase_d;
            halted_q   <= halted_d;
        end
    end

    // A store sourced from memory is illegal and degrades to a no-op.
    assign mem_we     = isExec && ctrl[C_STORE_MEM] && !ctrl[C_ASSERT_M];
    assign mem_wdata  = bus;
    assign ir         = ir_q;
    assign a_is_zero  = (a_q == 8'h00);
    assign flag_carry = carry_q;
    assign out_data   = out_q;
    assign out_valid  = outValid_q;
    assign phase      = phase_q[0];

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: the bench plays decoder and memory, stepping a small hand-written program.
module tb_cpu_datapath;

    localparam logic [14:0] LOAD_IR  = 15'h4000;
    localparam logic [14:0] LOAD_PC  = 15'h2000;
    localparam logic [14:0] LOAD_A   = 15'h1000;
    localparam logic [14:0] LOAD_B   = 15'h0800;
    localparam logic [14:0] LOAD_X   = 15'h0400;
    localparam logic [14:0] DO_OUT   = 15'h0200;
    localparam logic [14:0] STORE    = 15'h0100;
    localparam logic [14:0] AS_M     = 15'h0080;
    localparam logic [14:0] AS_E     = 15'h0040;
    localparam logic [14:0] AS_A     = 15'h0020;
    localparam logic [14:0] AS_X     = 15'h0010;
    localparam logic [14:0] IMM      = 15'h0008;
    localparam logic [14:0] JCTL     = 15'h0004;
    localparam logic [14:0] SUB      = 15'h0002;
    localparam logic [14:0] JMP      = 15'h0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] ctrl;
    logic [7:0]  ir;
    logic        aIsZero;
    logic        flagCarry;
    logic [7:0]  memAddr;
    logic [7:0]  memRdata;
    logic [7:0]  memWdata;
    logic        memWe;
    logic [7:0]  outData;
    logic        outValid;
    logic        phase;
`ifdef CPU_HALT_DETECT_EN
    logic        halted;
`endif

    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;

    cpu_datapath dut (
        .clk        (clk),
        .reset      (reset),
        .ctrl       (ctrl),
        .ir         (ir),
        .a_is_zero  (aIsZero),
        .flag_carry (flagCarry),
        .mem_addr   (memAddr),
        .mem_rdata  (memRdata),
        .mem_wdata  (memWdata),
        .mem_we     (memWe),
        .out_data   (outData),
        .out_valid  (outValid),
`ifdef CPU_HALT_DETECT_EN
        .halted     (halted),
`endif
        .phase      (phase)
    );

    always #5 clk = ~clk;

    assign memRdata = mem[memAddr];

    always @(posedge clk) begin
        if (memWe) mem[memAddr] <= memWdata;
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %02h, expected %02h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full instruction: fetch edge, then an exec edge with the given control word.
    task automatic applyStimulus(input logic [14:0] c);
        tick();
        ctrl = c;
        tick();
        ctrl = '0;
    endtask

    task automatic peek(input logic [14:0] sel, output logic [7:0] v);
        ctrl = sel;
        #1;
        v = memWdata;
        ctrl = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] v;
        ctrl  = '0;
        reset = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h01; mem[1] = 8'h05;
        mem[2] = 8'h02; mem[3] = 8'hF0;
        mem[4] = 8'h03; mem[5] = 8'h20;
        mem[6] = 8'h04; mem[7] = 8'h05;
        mem[8] = 8'h06; mem[9] = 8'h04;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_phase", {7'd0, phase}, 8'h00);
        checkOutput("rst_pc", memAddr, 8'h00);
        checkOutput("rst_ir", ir, 8'h00);
        checkOutput("rst_azero", {7'd0, aIsZero}, 8'h01);
        checkOutput("rst_carry", {7'd0, flagCarry}, 8'h00);
        checkOutput("rst_out", outData, 8'h00);
        checkOutput("rst_outvalid", {7'd0, outValid}, 8'h00);
        checkOutput("rst_we", {7'd0, memWe}, 8'h00);
        reset = 1'b0;

        applyStimulus(LOAD_A | AS_M | IMM);
        checkOutput("ldi_ir", ir, 8'h01);
        checkOutput("ldi_pc", memAddr, 8'h02);
        checkOutput("ldi_phase", {7'd0, phase}, 8'h00);
        checkOutput("ldi_azero", {7'd0, aIsZero}, 8'h00);
        peek(AS_A, v);
        checkOutput("ldi_a", v, 8'h05);

        applyStimulus(LOAD_A | AS_M | IMM);
        applyStimulus(LOAD_B | AS_M | IMM);
        applyStimulus(LOAD_A | AS_E);
        peek(AS_A, v);
        checkOutput("add_a", v, 8'h10);
        checkOutput("add_carry", {7'd0, flagCarry}, 8'h01);
        checkOutput("add_pc", memAddr, 8'h07);

        applyStimulus(LOAD_A | AS_E | SUB);
        peek(AS_A, v);
        checkOutput("sub_a", v, 8'hF0);
        checkOutput("sub_carry", {7'd0, flagCarry}, 8'h00);

        applyStimulus(LOAD_PC | AS_M | IMM | JCTL | JMP);
        checkOutput("jmp_to4", memAddr, 8'h04);

        mem[4] = 8'h30; mem[5] = 8'h40; mem[6] = 8'h31; mem[7] = 8'h04;
        applyStimulus(LOAD_PC | AS_M | IMM | JCTL);
        checkOutput("jnt_pc", memAddr, 8'h06);
        checkOutput("jnt_ir", ir, 8'h30);
        applyStimulus(LOAD_PC | AS_M | IMM | JCTL | JMP);
        checkOutput("jback_pc", memAddr, 8'h04);
        applyStimulus(LOAD_PC | AS_M | IMM | JCTL | JMP);
        checkOutput("jt_pc", memAddr, 8'h40);

        mem[8'h40] = 8'h07; mem[8'h41] = 8'h80;
        mem[8'h42] = 8'h01; mem[8'h43] = 8'h3C;
        mem[8'h44] = 8'h09; mem[8'h45] = 8'h0A;
        mem[8'h46] = 8'h0B; mem[8'h47] = 8'h0C;
        mem[8'h48] = 8'h0D; mem[8'h49] = 8'hFE;
        mem[8'hFE] = 8'h0E; mem[8'hFF] = 8'h77;
        applyStimulus(LOAD_X | AS_M | IMM);
        applyStimulus(LOAD_A | AS_M | IMM);
        peek(AS_X, v);
        checkOutput("ldx_x", v, 8'h80);

        tick();
        ctrl = STORE | AS_A;
        #1;
        checkOutput("st_we", {7'd0, memWe}, 8'h01);
        checkOutput("st_addr", memAddr, 8'h80);
        checkOutput("st_wdata", memWdata, 8'h3C);
        tick();
        ctrl = '0;
        checkOutput("st_mem", mem[8'h80], 8'h3C);
        checkOutput("st_we_after", {7'd0, memWe}, 8'h00);
        checkOutput("st_pc", memAddr, 8'h45);

        applyStimulus(DO_OUT | AS_A);
        checkOutput("out_valid_hi", {7'd0, outValid}, 8'h01);
        checkOutput("out_data", outData, 8'h3C);
        tick();
        checkOutput("out_valid_lo", {7'd0, outValid}, 8'h00);
        ctrl = STORE | AS_M;
        #1;
        checkOutput("illegal_we", {7'd0, memWe}, 8'h00);
        tick();
        ctrl = '0;

        tick();
        ctrl = LOAD_IR | AS_A;
        tick();
        ctrl = '0;
        checkOutput("ldir_phase", {7'd0, phase}, 8'h01);
        checkOutput("ldir_ir", ir, 8'h3C);
        tick();
        checkOutput("ldir_back", {7'd0, phase}, 8'h00);
        checkOutput("ldir_pc", memAddr, 8'h48);

        applyStimulus(LOAD_PC | AS_M | IMM | JMP);
        checkOutput("jfe_pc", memAddr, 8'hFE);
        applyStimulus(LOAD_B | AS_M | IMM);
        checkOutput("wrap_pc", memAddr, 8'h00);
        peek(AS_E, v);
        checkOutput("wrap_b_sum", v, 8'hB3);

        mem[0] = 8'h0F;
        mem[8'h80] = 8'h55;
        tick();
        ctrl = STORE | AS_A;
        #1;
        checkOutput("rstx_we_pre", {7'd0, memWe}, 8'h01);
        reset = 1'b1;
        #1;
        checkOutput("rstx_we", {7'd0, memWe}, 8'h00);
        checkOutput("rstx_phase", {7'd0, phase}, 8'h00);
        checkOutput("rstx_pc", memAddr, 8'h00);
        checkOutput("rstx_ir", ir, 8'h00);
        checkOutput("rstx_azero", {7'd0, aIsZero}, 8'h01);
        checkOutput("rstx_out", outData, 8'h00);
        ctrl = '0;
        tick();
        checkOutput("rstx_mem", mem[8'h80], 8'h55);
        peek(AS_X, v);
        checkOutput("rstx_x", v, 8'h00);
        reset = 1'b0;

`ifdef CPU_HALT_DETECT_EN
        mem[0] = 8'h20; mem[1] = 8'h10;
        mem[8'h10] = 8'h21; mem[8'h11] = 8'h10;
        applyStimulus(LOAD_PC | AS_M | IMM | JMP);
        checkOutput("halt_pre", {7'd0, halted}, 8'h00);
        applyStimulus(LOAD_PC | AS_M | IMM | JMP);
        checkOutput("halt_set", {7'd0, halted}, 8'h01);
        ctrl = STORE | AS_A | DO_OUT;
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("halt_pc", memAddr, 8'h10);
            checkOutput("halt_we", {7'd0, memWe}, 8'h00);
            checkOutput("halt_outv", {7'd0, outValid}, 8'h00);
        end
        ctrl = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
